// File: rtl/staged_coincidence_filter_if.sv
// staged_coincidence_filter_if: signal inputs, configuration and trigger outputs of the coincidence filter
interface staged_coincidence_filter_if #(
  parameter int N_CH  = 2,
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]       SIGNAL;
  logic                  read_mode;
  logic [2*N_CH+2*W-1:0] mconfig;
  logic                  TRIGGER_OUT;
  logic                  VETO_OUT;
  logic [CNT_W-1:0]      TRIGGER_COUNT;
  logic [1:0]            STATE;
  modport master (output SIGNAL, read_mode, mconfig, input TRIGGER_OUT, VETO_OUT, TRIGGER_COUNT, STATE);
  modport slave  (input SIGNAL, read_mode, mconfig, output TRIGGER_OUT, VETO_OUT, TRIGGER_COUNT, STATE);
endinterface

// File: rtl/staged_coincidence_filter.sv
// staged_coincidence_filter: stage-1 rise opens a [MIN,MAX] delay window, stage-2 rise inside it triggers.
// Define STAGED_FILTER_VETO_EN to let a stage-1 rise inside an open window abort it with a VETO_OUT pulse.
module staged_coincidence_filter #(
  parameter int N_CH    = 2,
  parameter int W       = 8,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input logic CLK,
  input logic RESET,
  staged_coincidence_filter_if.slave bus
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;
  state_t state, state_n;
  logic [N_CH-1:0] prev, rise, m1, m2;
  logic [W-1:0] mn, mx, c, c_n;
  logic [HW-1:0] h, h_n;
  logic [CNT_W-1:0] count, count_n;
  logic hit1, hit2, arm, qual, veto, trig, trig_n;
  assign m1   = bus.mconfig[N_CH-1:0];
  assign m2   = bus.mconfig[2*N_CH-1:N_CH];
  assign mn   = bus.mconfig[2*N_CH+W-1:2*N_CH];
  assign mx   = bus.mconfig[2*N_CH+2*W-1:2*N_CH+W];
  assign rise = bus.SIGNAL & ~prev;
  assign hit1 = |(rise & m1);
  assign hit2 = |(rise & m2);
  assign arm  = hit1 && mx != '0 && mn <= mx;
  assign qual = state == ARMED && !bus.read_mode && hit2 && c >= mn && c <= mx;
`ifdef STAGED_FILTER_VETO_EN
  logic veto_q;
  assign veto = state == ARMED && !bus.read_mode && hit1 && !qual;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) veto_q <= 1'b0;
    else veto_q <= veto;
  assign bus.VETO_OUT = veto_q;
`else
  assign veto = 1'b0;
  assign bus.VETO_OUT = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      prev  <= '0;
      c     <= '0;
      h     <= '0;
    end else begin
      state <= state_n;
      prev  <= bus.SIGNAL;
      c     <= c_n;
      h     <= h_n;
    end
  // the window closes on a qualifying hit, a veto or reaching MAX; holdoff is skipped when HOLDOFF is 0
  always_comb begin
    state_n = IDLE;
    c_n     = '0;
    h_n     = '0;
    if (bus.read_mode) state_n = IDLE;
    else if (state == IDLE) begin
      state_n = arm ? ARMED : IDLE;
      c_n     = arm ? W'(1) : '0;
    end else if (state == ARMED) begin
      state_n = qual ? (HOLDOFF > 0 ? HOLD : IDLE) : (veto || c == mx) ? IDLE : ARMED;
      c_n     = state_n == ARMED ? c + 1'b1 : '0;
    end else if (state == HOLD) begin
      state_n = h == H_LAST ? IDLE : HOLD;
      h_n     = state_n == HOLD ? h + 1'b1 : '0;
    end
  end
  always_comb begin
    trig_n  = qual;
    count_n = qual && !(&count) ? count + 1'b1 : count;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      trig  <= 1'b0;
      count <= '0;
    end else begin
      trig  <= trig_n;
      count <= count_n;
    end
  assign bus.TRIGGER_OUT   = trig;
  assign bus.TRIGGER_COUNT = count;
  assign bus.STATE         = state;
endmodule
